up_count_checker: RTL
=====================

// Module: up_count_checker
// PURPOSE
//   Downstream monitor for the free-running up counter's count bus. Samples count,
//   checks that each sample is exactly previous+1 (mod 2^WIDTH), locks onto a valid
//   sequence, and reports wrap-around events and sequence errors.
//   Saturating statistics feed status/debug logic. All outputs are registered.
// PARAMETERS
//   WIDTH   4  width of monitored count bus
//   LOCK_N  2  consecutive good increments needed to enter LOCK (>=1)
//   WRAP_W  8  width of wrap counter (saturating)
//   ERR_W   8  width of error counter (saturating)
// PORTS
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous, active-low reset
//   en        in   1       sample enable; tie 1 for a counter stepping every clk
//   clr       in   1       synchronous clear of wrap_cnt, err_cnt, err
//   count     in   WIDTH   counter value under check
//   locked    out  1       1 while FSM is in S_LOCK
//   wrap      out  1       1-cycle pulse: locked step from 2^WIDTH-1 to 0
//   wrap_cnt  out  WRAP_W  number of wraps, saturates at all-ones
//   err_pls   out  1       1-cycle pulse: bad step detected while locked
//   err       out  1       sticky error flag, cleared only by clr or rst
//   err_cnt   out  ERR_W   number of errors, saturates at all-ones
//   state     out  2       FSM state (debug): 0=S_INIT 1=S_ACQ 2=S_LOCK
// BEHAVIOUR
//   Reset (rst=0, async): all outputs 0, prev=0, good=0, state=S_INIT.
//   Nothing changes on edges with en=0; wrap/err_pls deassert (pulses last 1 clk).
//   exp = prev+1 truncated to WIDTH bits; prev<=count on every en edge.
//   S_INIT: en -> capture prev, good=0, go S_ACQ. No checks.
//   S_ACQ : en & count==exp -> good+1; if good+1==LOCK_N go S_LOCK, good=0.
//           en & count!=exp -> good=0, stay; no error reported while acquiring.
//   S_LOCK: en & count==exp -> stay; if prev==2^WIDTH-1 (count==0) -> wrap=1,
//           wrap_cnt+1 (hold at max).
//           en & count!=exp -> err_pls=1, err=1, err_cnt+1 (hold at max),
//           good=0, go S_ACQ (locked drops next edge).
//   Latency: status for the sample on edge N is visible after edge N (1 clk).
//   Upstream counter reset (jump to 0 from non-max) counts as one error.
//   A held count (upstream stalled) with en=1 is an error; gate en when stalled.
//   clr same edge as wrap/err event: counters and err cleared (clr wins);
//   wrap/err_pls pulses still fire; FSM unaffected by clr.
//   Illegal state encoding 3 -> S_INIT on next clk.
// TESTING
//   1 rst low 20ns, release; count 0,1,2,3.. en=1 -> locked=1 after 3rd en edge, err=0.
//   2 locked, count 14,15,0,1 -> wrap 1 clk after 0 sampled, wrap_cnt=1; 64 clks -> 4.
//   3 locked, count 6,7,9,10,11 -> err_pls 1 clk, err=1, err_cnt=1, locked=0, relock at 11.
//   4 free-run 300 wraps (WRAP_W=8) -> wrap_cnt=255 and holds; err_cnt stays 0.
//   5 clr=1 on the edge sampling 15->0 -> wrap=1, wrap_cnt=0, err=0 next clk.
//   6 rst low mid-lock, async -> all outputs 0 before next clk; state=0; en=0 -> no change.

Source files
------------

// File: rtl/up_count_checker.sv
// Monitor for a free-running up counter: acquires lock on a clean +1 sequence,
// then flags wrap-around steps and sequence breaks with saturating statistics.
module up_count_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count,
    output logic              locked,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_pls,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        state
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   prev;
    logic [GOOD_W-1:0]  good;
    logic [WIDTH-1:0]   exp_val;
    logic [GOOD_W-1:0]  good_nxt;
    logic               step_ok;
    logic               prev_max;

    function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
        return (&v) ? v : v + WRAP_W'(1);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign exp_val  = prev + WIDTH'(1);
    assign good_nxt = good + GOOD_W'(1);
    assign step_ok  = (count == exp_val);
    assign prev_max = &prev;
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_INIT;
            prev     <= '0;
            good     <= '0;
            locked   <= 1'b0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err_pls  <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            wrap    <= 1'b0;
            err_pls <= 1'b0;
            // clr only touches statistics; the FSM keeps tracking the sequence
            if (clr) begin
                wrap_cnt <= '0;
                err_cnt  <= '0;
                err      <= 1'b0;
            end
            if (en) begin
                prev <= count;
            end
            case (state_q)
                S_INIT: begin
                    if (en) begin
                        good    <= '0;
                        state_q <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (en) begin
                        if (step_ok) begin
                            if (good_nxt == GOOD_W'(LOCK_N)) begin
                                good    <= '0;
                                state_q <= S_LOCK;
                                locked  <= 1'b1;
                            end else begin
                                good <= good_nxt;
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                end
                S_LOCK: begin
                    if (en) begin
                        if (step_ok) begin
                            if (prev_max) begin
                                wrap <= 1'b1;
                                if (!clr) begin
                                    wrap_cnt <= sat_inc_wrap(wrap_cnt);
                                end
                            end
                        end else begin
                            err_pls <= 1'b1;
                            if (!clr) begin
                                err     <= 1'b1;
                                err_cnt <= sat_inc_err(err_cnt);
                            end
                            good    <= '0;
                            state_q <= S_ACQ;
                            locked  <= 1'b0;
                        end
                    end
                end
                default: begin
                    good    <= '0;
                    state_q <= S_INIT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
